idli_wb_m: RTL

- Write-back collector at the consumer end of the nibble-serial ALU datapath.
- Paces a multi-cycle operation with its own nibble counter and drives the last-cycle strobe back to the ALU.
- Samples ALU result nibbles LSB-first, assembles them into a full word and derives zero/negative/carry flags.
- Presents the word and flags to the register-file/flag writer over a valid/ready handshake.

---
 rtl/idli_wb_m.sv | 132 +++++++++++++
 1 files changed

// File: rtl/idli_wb_m.sv
// idli_wb_m: write-back collector for the nibble-serial ALU datapath.
// Counts the nibble cycles of an operation, drives the last-cycle strobe back
// to the ALU, assembles the LSB-first result nibbles into a word, derives the
// zero/negative/carry flags and offers the result downstream.
//
// Handshake: a result is transferred on a rising edge where o_wb_vld and
// i_wb_rdy are both high. o_wb_vld stays high and data/flags stay stable until
// that transfer. A new collection starts on an edge where o_wb_ack is high.
// o_wb_ack is high only in IDLE, or in HOLD while i_wb_rdy is high, so a
// transfer and the next start can share one edge with no bubble.
module idli_wb_m #(
  parameter int NIBBLES = 4,
  localparam int W  = 4 * NIBBLES,
  localparam int CW = $clog2(NIBBLES)
) (
  input  logic          i_wb_gck,
  input  logic          i_wb_rst_n,
  input  logic          i_wb_start,
  output logic          o_wb_ack,
  input  logic [3:0]    i_wb_nibble,
  input  logic          i_wb_cout,
  input  logic          i_wb_carry_en,
  output logic [CW-1:0] o_wb_ctr,
  output logic          o_wb_last_cycle,
  output logic          o_wb_busy,
  output logic          o_wb_vld,
  input  logic          i_wb_rdy,
  output logic [W-1:0]  o_wb_data,
  output logic          o_wb_zero,
  output logic          o_wb_neg,
  output logic          o_wb_carry
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  localparam logic [CW-1:0] CTR_LAST = CW'(NIBBLES - 1);

  state_t        state_q;
  logic [CW-1:0] ctr_q;
  logic [W-1:0]  data_q;
  logic [W-1:0]  data_d;
  logic          zrun_q;
  logic          zrun_d;
  logic          carry_en_q;
  logic          zero_q;
  logic          neg_q;
  logic          carry_q;
  logic          last_w;

  // Start acceptance, last-cycle decode and next values of the shift/zero chain.
  always_comb begin
    o_wb_ack = 1'b0;
    if (i_wb_rst_n && i_wb_start) begin
      if (state_q == ST_IDLE)
        o_wb_ack = 1'b1;
      else if (state_q == ST_HOLD && i_wb_rdy)
        o_wb_ack = 1'b1;
    end
    last_w = (state_q == ST_COLLECT) && (ctr_q == CTR_LAST);
    data_d = {i_wb_nibble, data_q[W-1:4]};
    zrun_d = zrun_q & (i_wb_nibble == 4'h0);
  end

  // Collector FSM: counter, word assembly, flag capture and result hold.
  always_ff @(posedge i_wb_gck) begin
    if (!i_wb_rst_n) begin
      state_q    <= ST_IDLE;
      ctr_q      <= '0;
      data_q     <= '0;
      zrun_q     <= 1'b0;
      carry_en_q <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_wb_start) begin
            state_q    <= ST_COLLECT;
            ctr_q      <= '0;
            carry_en_q <= i_wb_carry_en;
            zrun_q     <= 1'b1;
          end
        end
        ST_COLLECT: begin
          data_q <= data_d;
          zrun_q <= zrun_d;
          if (last_w) begin
            // Final nibble: flags are taken from the completed word.
            state_q <= ST_HOLD;
            ctr_q   <= '0;
            zero_q  <= zrun_d;
            neg_q   <= i_wb_nibble[3];
            carry_q <= carry_en_q & i_wb_cout;
          end else begin
            ctr_q <= ctr_q + CW'(1);
          end
        end
        ST_HOLD: begin
          if (i_wb_rdy) begin
            if (i_wb_start) begin
              state_q    <= ST_COLLECT;
              ctr_q      <= '0;
              carry_en_q <= i_wb_carry_en;
              zrun_q     <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ctr_q   <= '0;
        end
      endcase
    end
  end

  assign o_wb_ctr        = ctr_q;
  assign o_wb_last_cycle = last_w;
  assign o_wb_busy       = (state_q == ST_COLLECT);
  assign o_wb_vld        = (state_q == ST_HOLD);
  assign o_wb_data       = data_q;
  assign o_wb_zero       = zero_q;
  assign o_wb_neg        = neg_q;
  assign o_wb_carry      = carry_q;

endmodule
